// File: rtl/parking_gate_controller_pkg.sv
// Shared types and default sizing for the car-park gate controller.
package parking_pkg;
    typedef enum logic [1:0] {IDLE, OPEN, CLEAR} gate_state_t;

    localparam int DEF_CAPACITY = 7;
    localparam int DEF_DEBOUNCE = 4;
    localparam int DEF_TIMEOUT  = 255;
endpackage

// File: rtl/parking_gate_controller_if.sv
// Sensor inputs and barrier/counter outputs of the gate controller as one bundle.
interface parking_gate_controller_if #(
    parameter int OW = 3
);
    logic          in_req;
    logic          in_pass;
    logic          out_req;
    logic          out_pass;
    logic          gate_in_open;
    logic          gate_out_open;
    logic          cnt_up;
    logic          cnt_dn;
    logic [OW-1:0] occupancy;
    logic          full;
    logic          empty;
    logic          alarm;

    modport master (
        output in_req, in_pass, out_req, out_pass,
        input  gate_in_open, gate_out_open, cnt_up, cnt_dn, occupancy, full, empty, alarm
    );

    modport slave (
        input  in_req, in_pass, out_req, out_pass,
        output gate_in_open, gate_out_open, cnt_up, cnt_dn, occupancy, full, empty, alarm
    );
endinterface

// File: rtl/parking_gate_controller_gate_channel.sv
// One barrier: request/pass conditioning, IDLE/OPEN/CLEAR sequencing and open timer.
module gate_channel
    import parking_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic req_raw,
    input  logic pass_raw,
    input  logic admit,
    output logic gate_open,
    output logic count_event,
    output logic timeout_event
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]         raw, sync1_p0, sync2_p1, filt_p2, filt_q;
    logic [1:0][CW-1:0] dcnt;
    logic [1:0]         rise;
    logic [TW-1:0]      timer;
    gate_state_t        state;

    assign raw  = {pass_raw, req_raw};
    assign rise = filt_p2 & ~filt_q;

    // sync stage -> debounce stage; index 0 is req, index 1 is pass
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_p0 <= '0;
            sync2_p1 <= '0;
            filt_p2  <= '0;
            filt_q   <= '0;
            dcnt     <= '0;
        end else begin
            sync1_p0 <= raw;
            sync2_p1 <= sync1_p0;
            filt_q   <= filt_p2;
            for (int i = 0; i < 2; i++) begin
                if (sync2_p1[i] != filt_p2[i]) begin
                    if (dcnt[i] == CW'(DEBOUNCE - 1)) begin
                        filt_p2[i] <= sync2_p1[i];
                        dcnt[i]    <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + 1'b1;
                    end
                end else begin
                    dcnt[i] <= '0;
                end
            end
        end
    end

    // Opening keys off the request edge so a refused, still-held request cannot open later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            gate_open     <= 1'b0;
            count_event   <= 1'b0;
            timeout_event <= 1'b0;
            timer         <= '0;
        end else begin
            count_event   <= 1'b0;
            timeout_event <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise[0] && admit) begin
                        state     <= OPEN;
                        gate_open <= 1'b1;
                        timer     <= '0;
                    end
                end
                OPEN: begin
                    if (rise[1]) begin
                        state       <= CLEAR;
                        gate_open   <= 1'b0;
                        count_event <= 1'b1;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        state         <= CLEAR;
                        gate_open     <= 1'b0;
                        timeout_event <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CLEAR: begin
                    if (!filt_p2[0] && !filt_p2[1]) state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    gate_open <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/parking_gate_controller.sv
// Car-park gate controller: two gate channels feeding a saturating occupancy register.
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int OW       = $clog2(CAPACITY + 1)
) (
    input logic clk,
    input logic rst,
    parking_gate_controller_if.slave bus
);
    logic [OW-1:0] occ;
    logic          admit_in, admit_out;
    logic          in_evt_p0, out_evt_p0, in_to_p0, out_to_p0;
    logic          gate_in, gate_out;
    logic          up_p1, dn_p1, alarm_p1;

    assign admit_in  = (occ < OW'(CAPACITY));
    assign admit_out = (occ != '0);

    gate_channel #(.DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)) u_entry (
        .clk(clk), .rst(rst), .req_raw(bus.in_req), .pass_raw(bus.in_pass), .admit(admit_in),
        .gate_open(gate_in), .count_event(in_evt_p0), .timeout_event(in_to_p0)
    );

    gate_channel #(.DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)) u_exit (
        .clk(clk), .rst(rst), .req_raw(bus.out_req), .pass_raw(bus.out_pass), .admit(admit_out),
        .gate_open(gate_out), .count_event(out_evt_p0), .timeout_event(out_to_p0)
    );

    // event stage -> counter pulse stage; simultaneous entry and exit cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= '0;
            up_p1    <= 1'b0;
            dn_p1    <= 1'b0;
            alarm_p1 <= 1'b0;
        end else begin
            up_p1    <= 1'b0;
            dn_p1    <= 1'b0;
            alarm_p1 <= in_to_p0 | out_to_p0;
            if (in_evt_p0 && !out_evt_p0) begin
                if (occ < OW'(CAPACITY)) begin
                    occ   <= occ + 1'b1;
                    up_p1 <= 1'b1;
                end else begin
                    alarm_p1 <= 1'b1;
                end
            end else if (out_evt_p0 && !in_evt_p0) begin
                if (occ != '0) begin
                    occ   <= occ - 1'b1;
                    dn_p1 <= 1'b1;
                end else begin
                    alarm_p1 <= 1'b1;
                end
            end
        end
    end

    assign bus.gate_in_open  = gate_in;
    assign bus.gate_out_open = gate_out;
    assign bus.cnt_up        = up_p1;
    assign bus.cnt_dn        = dn_p1;
    assign bus.alarm         = alarm_p1;
    assign bus.occupancy     = occ;
    assign bus.full          = (occ == OW'(CAPACITY));
    assign bus.empty         = (occ == '0);
endmodule
